// File: rtl/clk_gate_ctrl.sv
// -----------------------------------------------------------------------------
// clk_gate_ctrl
//
// Enable-side controller for a glitch-less clock gate cell. Runs on the
// free-running clock and produces the registered enable for one clk_gate
// instance. The downstream clock is gated after a programmable run of
// consecutive idle cycles. It is restored by activity or by a 4-phase wake
// request/acknowledge handshake. A hard clk_disable forces the clock off and
// overrides every wake source.
//
// Parameters
//   CNT_W     width of the idle counter and of idle_thresh
//   WAKE_LAT  cycles clk_en is held high in WAKE before the clock is
//             considered stable (minimum 1)
//
// Ports
//   clk_in       in   free-running clock (ungated side of the gate)
//   rst_in       in   synchronous, active-high reset
//   idle_thresh  in   consecutive idle cycles before gating; 0 = never gate
//   busy         in   downstream activity, high = clock needed
//   wake_req     in   4-phase wake request (level, held until wake_ack)
//   clk_disable  in   hard force-off
//   clk_en       out  registered enable to clk_gate.clk_en
//   wake_ack     out  4-phase acknowledge: clock running and stable
//   gated        out  high while the clock is gated (state OFF)
//
// State table
//   state   | meaning
//   ST_ON   | clock running; idle cycles are counted toward gating
//   ST_OFF  | clock gated; waits for a wake source without clk_disable
//   ST_WAKE | clock re-enabled; waits WAKE_LAT cycles for it to settle
// -----------------------------------------------------------------------------
module clk_gate_ctrl #(
  parameter int CNT_W    = 8,
  parameter int WAKE_LAT = 2
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [CNT_W-1:0] idle_thresh,
  input  logic             busy,
  input  logic             wake_req,
  input  logic             clk_disable,
  output logic             clk_en,
  output logic             wake_ack,
  output logic             gated
);

  localparam int WCNT_W = (WAKE_LAT > 1) ? $clog2(WAKE_LAT) : 1;
  localparam logic [WCNT_W-1:0] WAKE_LAST = WCNT_W'(WAKE_LAT - 1);

  typedef enum logic [1:0] {
    ST_ON   = 2'd0,
    ST_OFF  = 2'd1,
    ST_WAKE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  idle_cnt_q, idle_cnt_d;
  logic [WCNT_W-1:0] wake_cnt_q, wake_cnt_d;
  logic              clk_en_q, clk_en_d;
  logic              wake_ack_q, wake_ack_d;
  logic              gated_q, gated_d;

  logic              idle;
  logic              wake_src;
  logic              thresh_hit;

  // An outstanding acknowledge counts as activity so the clock can never be
  // gated underneath an initiator that still believes it is running.
  assign idle     = !busy && !wake_req && !wake_ack_q;
  assign wake_src = (busy || wake_req) && !clk_disable;

  // Compared against the live threshold every cycle, so reprogramming takes
  // effect immediately.
  assign thresh_hit = (idle_cnt_q == (idle_thresh - CNT_W'(1)));

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = '0;
    wake_cnt_d = wake_cnt_q;

    case (state_q)
      ST_ON: begin
        if (clk_disable) begin
          state_d = ST_OFF;
        end else if (idle && (idle_thresh != '0)) begin
          if (thresh_hit) begin
            state_d = ST_OFF;
          end else if (idle_cnt_q != '1) begin
            idle_cnt_d = idle_cnt_q + CNT_W'(1);
          end else begin
            idle_cnt_d = idle_cnt_q;
          end
        end
      end

      ST_OFF: begin
        if (wake_src) begin
          state_d    = ST_WAKE;
          wake_cnt_d = '0;
        end
      end

      ST_WAKE: begin
        // Dropping busy/wake_req here does not abort the wake; only a hard
        // disable does.
        if (clk_disable) begin
          state_d = ST_OFF;
        end else if (wake_cnt_q == WAKE_LAST) begin
          state_d = ST_ON;
        end else begin
          wake_cnt_d = wake_cnt_q + WCNT_W'(1);
        end
      end

      default: begin
        state_d = ST_ON;
      end
    endcase
  end

  always_comb begin
    wake_ack_d = wake_ack_q;
    if (clk_disable) begin
      wake_ack_d = 1'b0;
    end else if ((state_q == ST_ON) && wake_req) begin
      // Also re-acks a request raised before the previous ack was seen low.
      wake_ack_d = 1'b1;
    end else if (!wake_req) begin
      wake_ack_d = 1'b0;
    end
  end

  // Outputs are registered from the next state so clk_en tracks the state
  // register exactly, with no input-to-output combinational path.
  always_comb begin
    clk_en_d = (state_d != ST_OFF);
    gated_d  = (state_d == ST_OFF);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= ST_ON;
      idle_cnt_q <= '0;
      wake_cnt_q <= '0;
      clk_en_q   <= 1'b1;
      wake_ack_q <= 1'b0;
      gated_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      wake_cnt_q <= wake_cnt_d;
      clk_en_q   <= clk_en_d;
      wake_ack_q <= wake_ack_d;
      gated_q    <= gated_d;
    end
  end

  assign clk_en   = clk_en_q;
  assign wake_ack = wake_ack_q;
  assign gated    = gated_q;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for clk_gate_ctrl. A behavioural model tracks whether the clock is
// off, how many settle cycles remain after a wake, the length of the current
// idle run and the acknowledge level; a compare process checks all three
// outputs against it on every falling edge. Directed sequences pin the model
// with hand-computed latencies, then a randomized phase exercises the rest.
// -----------------------------------------------------------------------------
module tb_clk_gate_ctrl;

  localparam int CNT_W    = 8;
  localparam int WAKE_LAT = 2;

  localparam int SEL_CLK_EN = 0;
  localparam int SEL_ACK    = 1;
  localparam int SEL_GATED  = 2;

  logic             clk_in = 1'b0;
  logic             rst_in;
  logic [CNT_W-1:0] idle_thresh;
  logic             busy;
  logic             wake_req;
  logic             clk_disable;
  logic             clk_en;
  logic             wake_ack;
  logic             gated;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // Reference model state
  bit m_off      = 1'b0;
  bit m_ack      = 1'b0;
  int m_wake_rem = 0;
  int m_run      = 0;

  always #5 clk_in = ~clk_in;

  clk_gate_ctrl #(
    .CNT_W   (CNT_W),
    .WAKE_LAT(WAKE_LAT)
  ) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .idle_thresh(idle_thresh),
    .busy       (busy),
    .wake_req   (wake_req),
    .clk_disable(clk_disable),
    .clk_en     (clk_en),
    .wake_ack   (wake_ack),
    .gated      (gated)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model update: one step per rising edge from the inputs held across it.
  task automatic model_step();
    bit idle, src, running, nack;
    if (rst_in) begin
      m_off = 1'b0; m_ack = 1'b0; m_wake_rem = 0; m_run = 0;
    end else begin
      idle    = !busy && !wake_req && !m_ack;
      src     = (busy || wake_req) && !clk_disable;
      running = !m_off && (m_wake_rem == 0);

      if (clk_disable)            nack = 1'b0;
      else if (running && wake_req) nack = 1'b1;
      else if (!wake_req)         nack = 1'b0;
      else                        nack = m_ack;

      if (clk_disable) begin
        m_off = 1'b1; m_wake_rem = 0; m_run = 0;
      end else if (m_off) begin
        if (src) begin
          m_off = 1'b0; m_wake_rem = WAKE_LAT;
        end
        m_run = 0;
      end else if (m_wake_rem > 0) begin
        m_wake_rem--; m_run = 0;
      end else if (idle && (idle_thresh != 0)) begin
        // Gate once the idle run reaches idle_thresh cycles.
        if (m_run == int'(idle_thresh) - 1) begin
          m_off = 1'b1; m_run = 0;
        end else begin
          m_run++;
        end
      end else begin
        m_run = 0;
      end
      m_ack = nack;
    end
  endtask

  initial forever begin
    @(posedge clk_in);
    model_step();
  end

  initial forever begin
    @(negedge clk_in);
    if (chk_en) begin
      check("cmp_clk_en",   {31'd0, clk_en},   {31'd0, !m_off});
      check("cmp_gated",    {31'd0, gated},    {31'd0, m_off});
      check("cmp_wake_ack", {31'd0, wake_ack}, {31'd0, m_ack});
    end
  end

  function automatic logic sel(input int w);
    case (w)
      SEL_CLK_EN: return clk_en;
      SEL_ACK:    return wake_ack;
      default:    return gated;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  // Count falling edges until the selected output reads v; gives up at limit.
  task automatic count_until(input int w, input logic v, input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk_in);
      n++;
    end while ((sel(w) !== v) && (n < limit));
  endtask

  initial begin
    int n;
    int low_cnt;

    rst_in = 1'b1; busy = 1'b0; wake_req = 1'b0; clk_disable = 1'b0;
    idle_thresh = 8'd4;
    @(posedge clk_in);
    #1 chk_en = 1'b1;

    // Reset and idle gating
    tick(2);
    check("rst_clk_en", {31'd0, clk_en}, 1);
    check("rst_gated",  {31'd0, gated},  0);
    check("rst_ack",    {31'd0, wake_ack}, 0);
    rst_in = 1'b0;
    count_until(SEL_CLK_EN, 1'b0, 20, n);
    check("t1_gate_latency", n, 4);
    check("t1_gated", {31'd0, gated}, 1);

    // Busy pulse on idle cycle 3 restarts the count
    rst_in = 1'b1; tick(1); rst_in = 1'b0;
    tick(2);
    busy = 1'b1; tick(1); busy = 1'b0;
    check("t2_no_gate", {31'd0, clk_en}, 1);
    count_until(SEL_CLK_EN, 1'b0, 20, n);
    check("t2_gate_after_busy", n, 4);

    // Wake handshake from OFF
    wake_req = 1'b1;
    tick(1);
    check("t3_clk_en_1edge", {31'd0, clk_en}, 1);
    count_until(SEL_ACK, 1'b1, 20, n);
    check("t3_ack_latency", n + 1, WAKE_LAT + 2);
    wake_req = 1'b0;
    tick(1);
    check("t3_ack_fall", {31'd0, wake_ack}, 0);
    count_until(SEL_CLK_EN, 1'b0, 20, n);
    check("t3_regate", n, 4);

    // clk_disable override
    busy = 1'b1; wake_req = 1'b1;
    count_until(SEL_ACK, 1'b1, 20, n);
    check("t4_ack_latency", n, WAKE_LAT + 2);
    clk_disable = 1'b1;
    tick(1);
    check("t4_dis_clk_en", {31'd0, clk_en},   0);
    check("t4_dis_gated",  {31'd0, gated},    1);
    check("t4_dis_ack",    {31'd0, wake_ack}, 0);
    tick(5);
    check("t4_dis_hold", {31'd0, gated}, 1);
    clk_disable = 1'b0;
    tick(1);
    check("t4_wake_clk_en", {31'd0, clk_en}, 1);
    count_until(SEL_ACK, 1'b1, 20, n);
    check("t4_reack", n + 1, WAKE_LAT + 2);

    // Gating disabled, then maximum threshold
    busy = 1'b0; wake_req = 1'b0; idle_thresh = 8'd0;
    tick(1);
    low_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      tick(1);
      if (clk_en !== 1'b1) low_cnt++;
    end
    check("t5_thresh0_never_gates", low_cnt, 0);
    idle_thresh = 8'd255;
    count_until(SEL_CLK_EN, 1'b0, 400, n);
    check("t5_thresh255", n, 255);

    // Reset in the middle of WAKE
    idle_thresh = 8'd4;
    busy = 1'b1;
    tick(1);
    check("t6_in_wake", {31'd0, clk_en}, 1);
    busy = 1'b0; wake_req = 1'b1;
    tick(1);
    rst_in = 1'b1;
    tick(1);
    check("t6_rst_clk_en", {31'd0, clk_en},   1);
    check("t6_rst_gated",  {31'd0, gated},    0);
    check("t6_rst_ack",    {31'd0, wake_ack}, 0);
    rst_in = 1'b0;
    tick(1);
    check("t6_ack_from_on", {31'd0, wake_ack}, 1);
    wake_req = 1'b0;
    tick(1);

    // Randomized phase
    for (int i = 0; i < 4000; i++) begin
      tick(1);
      rst_in = ($urandom_range(0, 299) == 0);
      if (clk_disable) clk_disable = ($urandom_range(0, 5) != 0);
      else             clk_disable = ($urandom_range(0, 39) == 0);
      busy = ($urandom_range(0, 11) == 0);
      if (!wake_req && !wake_ack && ($urandom_range(0, 24) == 0))
        wake_req = 1'b1;
      else if (wake_req && wake_ack && ($urandom_range(0, 2) == 0))
        wake_req = 1'b0;
      else if (wake_req && !wake_ack && ($urandom_range(0, 49) == 0))
        wake_req = 1'b0;
      if ($urandom_range(0, 99) == 0)
        idle_thresh = 8'($urandom_range(0, 12));
    end

    rst_in = 1'b0; busy = 1'b0; wake_req = 1'b0; clk_disable = 1'b0;
    tick(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clk_gate_ctrl.md
Name: clk_gate_ctrl

Overview:
- Enable-side controller for the glitch-less clock gate cell. It runs on the free-running clock and produces the registered clk_en that drives the gate.
- Gates the downstream clock after a programmable number of consecutive idle cycles.
- Restores the clock on activity or on a 4-phase wake request/acknowledge handshake, and honours a hard clk_disable.
- Sits between block-level activity/power-management logic and one clk_gate instance.

Parameters:
- CNT_W, 8, width of idle counter and idle_thresh.
- WAKE_LAT, 2, cycles clk_en is held high in WAKE before the block is considered clock-stable (min 1).

Ports:
- clk_in  input  1  free-running clock (ungated side of the gate).
- rst_in  input  1  reset; synchronous, active-high.
- idle_thresh  input  CNT_W  consecutive idle cycles before gating; 0 = auto-gating disabled.
- busy  input  1  downstream activity; high = clock needed.
- wake_req  input  1  4-phase wake request from initiator; level, held until wake_ack.
- clk_disable  input  1  hard force-off; overrides all wake sources.
- clk_en  output  1  registered enable to clk_gate.clk_en.
- wake_ack  output  1  4-phase acknowledge; clock is running and stable.
- gated  output  1  status; high while in OFF.

Behaviour:
- Reset, synchronous: state=ON, clk_en=1, wake_ack=0, gated=0, idle_cnt=0, wake_cnt=0. A reset mid-operation in any state returns to these values on the next edge.
- Definitions:
  - idle = !busy & !wake_req & !wake_ack.
  - wake_src = (busy | wake_req) & !clk_disable.
- All outputs are registered. There is no combinational path from inputs to outputs.
- State ON:
  - clk_en=1.
  - clk_disable=1 -> OFF next edge, taking priority over everything.
  - Otherwise, if idle and idle_thresh!=0: idle_cnt increments, saturating at all-ones.
  - When idle_cnt==idle_thresh-1 and idle holds -> OFF next edge, idle_cnt<=0. Result: clk_en falls exactly idle_thresh cycles after idle begins.
  - Any non-idle cycle, or idle_thresh==0 -> idle_cnt<=0 and the state stays ON.
  - idle_thresh changing while counting: the compare uses the current value each cycle.
- State OFF:
  - clk_en=0, gated=1, idle_cnt held at 0.
  - wake_src -> WAKE next edge, wake_cnt<=0.
  - clk_disable=1 holds OFF even with busy/wake_req high.
- State WAKE:
  - clk_en=1, gated=0. wake_cnt increments.
  - When wake_cnt==WAKE_LAT-1 -> ON.
  - clk_disable=1 during WAKE -> OFF next edge, abandoning the wake.
  - busy/wake_req dropping during WAKE does not abort; the FSM completes to ON. The normal idle count then applies.
- wake_ack, 4-phase handshake:
  - Rises on the edge after a cycle where state==ON & wake_req & !clk_disable.
  - Falls on the edge after wake_req is sampled low.
  - While wake_ack=1, idle is false, so no auto-gating occurs.
  - clk_disable=1 while wake_ack=1: wake_ack falls next edge and the FSM goes OFF.
  - Initiator rule: wake_req must not rise again until wake_ack is seen low. The block tolerates a violation by simply re-acking.
- Wake latency: wake_req rising in OFF gives wake_ack high exactly WAKE_LAT+2 edges later. The +2 is one edge for OFF->WAKE and one edge for the ack register.
- Wake_req rising while already ON: wake_ack high on the next edge (1 cycle).
- Simultaneous events, priority: rst_in > clk_disable > wake_src > idle-count.
- Width: idle_cnt is CNT_W bits. It never wraps; it saturates.

Test Plan:
- Reset, idle gating:
  - Stimulus: assert rst_in 2 cycles, then idle_thresh=4, busy=0, wake_req=0.
  - Required: after reset clk_en=1, gated=0, wake_ack=0; clk_en falls 4 cycles after reset release; gated=1 in the same cycle.
- Activity restarts the count:
  - Stimulus: idle_thresh=4, busy pulses high for 1 cycle at idle cycle 3.
  - Required: no gating; clk_en then falls 4 cycles after the busy pulse.
- Wake handshake from OFF, WAKE_LAT=2:
  - Stimulus: while OFF, raise wake_req.
  - Required: clk_en=1 after 1 edge; wake_ack=1 after 4 edges; drop wake_req -> wake_ack=0 next edge; gating resumes after idle_thresh further idle cycles.
- clk_disable override:
  - Stimulus: busy=1 and wake_req=1 with wake_ack=1, then assert clk_disable.
  - Required: next edge clk_en=0, gated=1, wake_ack=0; stays OFF while clk_disable=1; deassert -> WAKE then ON within WAKE_LAT+1 edges.
- Gating disabled and saturation:
  - Stimulus: idle_thresh=0, idle for 300 cycles with CNT_W=8.
  - Required: clk_en stays 1 throughout; idle_cnt stays 0.
  - Stimulus: set idle_thresh=255.
  - Required: clk_en falls exactly 255 cycles later.
- Reset mid-WAKE:
  - Stimulus: assert rst_in on wake_cnt=1.
  - Required: next edge state=ON, clk_en=1, wake_ack=0, gated=0.
